store_buffer: RTL and testbench

Posted-write buffer between the single-cycle CPU's data-memory port and a slow, handshaked data memory. Stores from the CPU are queued and retired to memory in the background, so a store costs no CPU stall cycles unless the buffer is full. Loads first search the buffer, then go to memory, stalling the CPU until data is returned. The CPU treats `cpu_stall` as a global hold: no PC update and no register-file write while it is high.

---
 rtl/store_buffer_pkg.sv | 27 ++
 rtl/store_buffer_if.sv | 38 +++
 rtl/sb_fifo.sv | 94 +++++++++
 rtl/store_buffer.sv | 149 ++++++++++++++
 tb/tb_store_buffer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_pkg
// Purpose  : Shared default sizes, state encoding and entry layout for the
//            CPU posted-write store buffer.
// Revision : 1.0
// ============================================================================
package store_buffer_pkg;

    localparam int c_DEPTH  = 4;
    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    // Word address (byte address without bits [1:0]) plus store data.
    typedef struct packed {
        logic [c_ADDR_W-3:0] addr;
        logic [c_DATA_W-1:0] data;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Purpose  : CPU data port and memory port of the store buffer, bundled.
// Revision : 1.0
// ============================================================================
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) ();

    logic              cpu_we;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wd;
    logic [DATA_W-1:0] cpu_rd;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wd, mem_ack, mem_rdata,
        output cpu_rd, cpu_stall, mem_req, mem_we, mem_addr, mem_wd
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wd, mem_ack, mem_rdata,
        input  cpu_rd, cpu_stall, mem_req, mem_we, mem_addr, mem_wd
    );

endinterface
`default_nettype wire

// File: rtl/sb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sb_fifo
// Purpose  : Circular store queue with head/tail pointers and a count.
//            With STORE_BUFFER_FWD_EN defined it adds a youngest-first lookup.
// Revision : 1.0
// ============================================================================
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-3:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [ADDR_W-3:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_full,
    output logic              o_empty
`ifdef STORE_BUFFER_FWD_EN
    ,
    input  logic [ADDR_W-3:0] i_lookup_addr,
    output logic              o_lookup_hit,
    output logic [DATA_W-1:0] o_lookup_data
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-3:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign o_full      = (r_count == c_CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push_ok   = i_push && !o_full;
    assign w_pop_ok    = i_pop && !o_empty;
    assign o_head_addr = r_mem[r_head].addr;
    assign o_head_data = r_mem[r_head].data;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_tail] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop_ok)  r_head <= r_head + c_PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        o_lookup_hit  = 1'b0;
        o_lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CNT_W'(i) < r_count) &&
                (r_mem[r_head + c_PTR_W'(i)].addr == i_lookup_addr)) begin
                o_lookup_hit  = 1'b1;
                o_lookup_data = r_mem[r_head + c_PTR_W'(i)].data;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Posted-write buffer between the CPU data port and a handshaked
//            memory. Load forwarding is enabled by STORE_BUFFER_FWD_EN.
// Revision : 1.0
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);

    sb_state_t         r_state;
    sb_state_t         w_next_state;
    logic [DATA_W-1:0] r_rd_q;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-3:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    logic              w_stall;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wd;
    logic [DATA_W-1:0] w_cpu_rd;
    logic              w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^bus.cpu_addr[1:0];

    sb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_addr   (bus.cpu_addr[ADDR_W-1:2]),
        .i_push_data   (bus.cpu_wd),
        .i_pop         (w_pop),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_full        (w_full),
        .o_empty       (w_empty)
`ifdef STORE_BUFFER_FWD_EN
        ,
        .i_lookup_addr (bus.cpu_addr[ADDR_W-1:2]),
        .o_lookup_hit  (w_hit),
        .o_lookup_data (w_hit_data)
`endif
    );

`ifndef STORE_BUFFER_FWD_EN
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q <= '0;
        end else if (r_state == LOAD && bus.mem_ack) begin
            r_rd_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wd     = '0;
        w_cpu_rd     = '0;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_mem_req  = 1'b1;
                    w_mem_we   = 1'b1;
                    w_mem_addr = {w_head_addr, 2'b00};
                    w_mem_wd   = w_head_data;
                    w_pop      = bus.mem_ack;
                end
                if (bus.cpu_we) begin
                    w_stall = w_full;
                    w_push  = !w_full;
                end else if (bus.cpu_re) begin
                    if (w_hit) begin
                        w_cpu_rd = w_hit_data;
                    end else begin
                        // The read waits for the queue to drain so it never
                        // overtakes an older store.
                        w_stall = 1'b1;
                        if (w_empty) w_next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                w_stall    = 1'b1;
                if (bus.mem_ack) w_next_state = DONE;
            end
            DONE: begin
                w_cpu_rd     = r_rd_q;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase

        if (rst) begin
            w_stall   = 1'b0;
            w_cpu_rd  = '0;
            w_mem_req = 1'b0;
            w_mem_we  = 1'b0;
            w_mem_addr = '0;
            w_mem_wd  = '0;
        end
    end

    assign bus.cpu_stall = w_stall;
    assign bus.cpu_rd    = w_cpu_rd;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wd    = w_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer against a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queued stores plus a pending/finished read.
    sb_entry_t   q[$];
    bit          m_read, m_done;
    logic [31:0] m_rd;

    // CPU instruction currently held and memory responder settings.
    bit          c_we, c_re;
    logic [31:0] c_addr, c_wd;
    int          ack_lat, ack_cnt;
    bit          ack_rand, ack_force;
    logic [31:0] rdata_val;

    logic [31:0] wlog_a[$], wlog_d[$];
    int          stall_cycles, rdreq_cycles;
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r);
        bit e_req, e_we, e_stall, hit, ack;
        logic [31:0] e_addr, e_wd, e_rd;
        int sz0;
        e_req = 0; e_we = 0; e_stall = 0; hit = 0; ack = 0;
        e_addr = '0; e_wd = '0; e_rd = '0;
        sz0 = q.size();
        if (m_done) begin
            e_rd = m_rd;
        end else if (m_read) begin
            e_req = 1; e_addr = {c_addr[31:2], 2'b00}; e_stall = 1;
        end else begin
            if (sz0 > 0) begin
                e_req = 1; e_we = 1; e_addr = {q[0].addr, 2'b00}; e_wd = q[0].data;
            end
            if (c_we) e_stall = (sz0 == DEPTH);
            else if (c_re) begin
`ifdef STORE_BUFFER_FWD_EN
                foreach (q[i]) if (q[i].addr == c_addr[31:2]) begin hit = 1; e_rd = q[i].data; end
`endif
                if (!hit) e_stall = 1;
            end
        end
        if (ack_force) ack = 1;
        else if (ack_rand) ack = e_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
        else if (e_req && ack_lat > 0 && !r) begin
            if (ack_cnt == ack_lat - 1) begin ack = 1; ack_cnt = 0; end
            else ack_cnt++;
        end

        rst = r;
        bus.cpu_we = c_we; bus.cpu_re = c_re; bus.cpu_addr = c_addr; bus.cpu_wd = c_wd;
        bus.mem_ack = ack; bus.mem_rdata = rdata_val;
        @(negedge clk);

        if (r) begin
            check("rst_stall", bus.cpu_stall, 0);
            check("rst_cpu_rd", bus.cpu_rd, 0);
        end else begin
            check("stall", bus.cpu_stall, e_stall);
            check("mem_req", bus.mem_req, e_req);
            check("count", dut.u_fifo.r_count, sz0);
            if (e_req) begin
                check("mem_we", bus.mem_we, e_we);
                check("mem_addr", bus.mem_addr, e_addr);
                if (e_we) check("mem_wd", bus.mem_wd, e_wd);
            end
            if (c_re && !e_stall) begin
                check("cpu_rd", bus.cpu_rd, e_rd);
                last_rd = bus.cpu_rd;
            end
            if (bus.cpu_stall) stall_cycles++;
            if (bus.mem_req && !bus.mem_we) rdreq_cycles++;
            if (bus.mem_req && bus.mem_we && ack) begin
                wlog_a.push_back(bus.mem_addr);
                wlog_d.push_back(bus.mem_wd);
            end
        end

        if (r) begin
            q.delete(); m_read = 0; m_done = 0; m_rd = '0; ack_cnt = 0; c_we = 0; c_re = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_read) begin
            if (ack) begin m_rd = rdata_val; m_read = 0; m_done = 1; end
        end else begin
            if (sz0 > 0 && ack) void'(q.pop_front());
            if (c_we && sz0 < DEPTH) q.push_back(sb_entry_t'{addr: c_addr[31:2], data: c_wd});
            if (c_re && !hit && sz0 == 0) m_read = 1;
        end
        if (!r && !e_stall) begin c_we = 0; c_re = 0; end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
        c_we = we; c_re = re; c_addr = a; c_wd = d;
        for (int n = 0; n < 200 && (c_we || c_re); n++) step(0);
        if (c_we || c_re) begin
            total++; bad++;
            $display("FAIL op_timeout: actual=still_stalled required=complete addr=%0h", a);
            c_we = 0; c_re = 0;
        end
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 300 && (q.size() > 0 || m_read || m_done); n++) step(0);
        if (q.size() > 0 || m_read || m_done) begin
            total++; bad++;
            $display("FAIL drain_timeout: actual=%0d queued required=0", q.size());
        end
    endtask

    task automatic set_lat(input int lat);
        ack_lat = lat; ack_cnt = 0;
    endtask

    task automatic idle_outputs_zero(input string tag);
        rst = 1'b0; bus.cpu_we = 0; bus.cpu_re = 0; bus.mem_ack = 0;
        #1;
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wd"}, bus.mem_wd, 0);
        check({tag, "_cpu_rd"}, bus.cpu_rd, 0);
        check({tag, "_stall"}, bus.cpu_stall, 0);
        check({tag, "_count"}, dut.u_fifo.r_count, 0);
    endtask

    initial begin
        int bw, bs, br;
        m_read = 0; m_done = 0; m_rd = '0;
        c_we = 0; c_re = 0; c_addr = '0; c_wd = '0;
        ack_lat = 0; ack_cnt = 0; ack_rand = 0; ack_force = 0;
        rdata_val = '0; stall_cycles = 0; rdreq_cycles = 0; last_rd = '0;

        step(1); step(1);
        idle_outputs_zero("reset");

        // Three posted stores, ack on the third request cycle.
        set_lat(3);
        bw = wlog_a.size(); bs = stall_cycles;
        run_op(1, 0, 32'h10, 32'hA);
        run_op(1, 0, 32'h14, 32'hB);
        run_op(1, 0, 32'h18, 32'hC);
        wait_empty();
        check("t1_stalls", stall_cycles - bs, 0);
        check("t1_nwrites", wlog_a.size() - bw, 3);
        if (wlog_a.size() - bw == 3) begin
            check("t1_w0", {wlog_a[bw], wlog_d[bw]}, {32'h10, 32'hA});
            check("t1_w1", {wlog_a[bw+1], wlog_d[bw+1]}, {32'h14, 32'hB});
            check("t1_w2", {wlog_a[bw+2], wlog_d[bw+2]}, {32'h18, 32'hC});
        end

        // Full buffer: fifth store stalls until one ack frees a slot.
        set_lat(0);
        bs = stall_cycles; bw = wlog_a.size();
        for (int i = 0; i < 4; i++) run_op(1, 0, 32'h200 + 32'(4 * i), 32'(i + 1));
        check("t2_no_stall", stall_cycles - bs, 0);
        c_we = 1; c_re = 0; c_addr = 32'h210; c_wd = 32'h5;
        step(0); step(0);
        check("t2_stall_5th", stall_cycles - bs, 2);
        ack_force = 1; step(0); ack_force = 0;
        step(0);
        check("t2_stall_total", stall_cycles - bs, 3);
        check("t2_count_full", dut.u_fifo.r_count, 4);
        check("t2_writes", wlog_a.size() - bw, 1);
        set_lat(1);
        wait_empty();

        // Two stores to the same word, then a load of it.
        set_lat(0);
        run_op(1, 0, 32'h20, 32'h1);
        run_op(1, 0, 32'h20, 32'h2);
        bs = stall_cycles; br = rdreq_cycles; bw = wlog_a.size();
`ifdef STORE_BUFFER_FWD_EN
        run_op(0, 1, 32'h20, 32'h0);
        check("t3_fwd_rd", last_rd, 32'h2);
        check("t3_fwd_stall", stall_cycles - bs, 0);
        check("t3_fwd_noread", rdreq_cycles - br, 0);
        set_lat(1);
        wait_empty();
`else
        set_lat(2);
        rdata_val = 32'hCAFEF00D;
        run_op(0, 1, 32'h20, 32'h0);
        check("t3_rd", last_rd, 32'hCAFEF00D);
        check("t3_writes", wlog_a.size() - bw, 2);
        if (wlog_a.size() - bw == 2) begin
            check("t3_w0", wlog_d[bw], 32'h1);
            check("t3_w1", wlog_d[bw+1], 32'h2);
        end
        check("t3_readcycles", rdreq_cycles - br, 2);
`endif

        // Two queued stores then a missing load; memory answers on 2nd cycle.
        set_lat(2);
        run_op(1, 0, 32'h44, 32'h11);
        run_op(1, 0, 32'h48, 32'h22);
        bs = stall_cycles; br = rdreq_cycles;
        rdata_val = 32'h12345678;
        run_op(0, 1, 32'h40, 32'h0);
        check("t4_rd", last_rd, 32'h12345678);
        check("t4_stalls", stall_cycles - bs, 6);
        check("t4_readcycles", rdreq_cycles - br, 2);

        // Steady push+pop at DEPTH-1 over 3*DEPTH stores.
        set_lat(0);
        bw = wlog_a.size();
        for (int i = 0; i < 3; i++) run_op(1, 0, 32'h300 + 32'(4 * i), 32'h100 + 32'(i));
        set_lat(1);
        for (int i = 3; i < 3 + 3 * DEPTH; i++) run_op(1, 0, 32'h300 + 32'(4 * i), 32'h100 + 32'(i));
        check("t5_count", dut.u_fifo.r_count, 3);
        check("t5_model_count", q.size(), 3);
        check("t5_nwrites", wlog_a.size() - bw, 3 * DEPTH);
        for (int k = 0; k < 3 * DEPTH && bw + k < wlog_a.size(); k++)
            check("t5_order", {wlog_a[bw+k], wlog_d[bw+k]}, {32'h300 + 32'(4 * k), 32'h100 + 32'(k)});
        wait_empty();

        // Reset while a read is in flight; a late ack must be ignored.
        set_lat(0);
        c_we = 0; c_re = 1; c_addr = 32'h50; c_wd = '0;
        step(0); step(0); step(0);
        step(1);
        idle_outputs_zero("t6");
        ack_force = 1; step(0); ack_force = 0;
        check("t6_late_ack_count", dut.u_fifo.r_count, 0);
        check("t6_late_ack_req", bus.mem_req, 0);
        check("t6_late_ack_stall", bus.cpu_stall, 0);
        run_op(1, 0, 32'h60, 32'h77);
        run_op(1, 0, 32'h64, 32'h88);
        step(1);
        idle_outputs_zero("t6b");

        // Randomised traffic with random acks and occasional resets.
        ack_rand = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rdata_val = $urandom;
            if (!c_we && !c_re) begin
                int sel;
                sel = $urandom_range(0, 9);
                c_addr = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                c_wd = $urandom;
                c_we = (sel <= 3);
                c_re = (sel >= 4 && sel <= 6);
            end
            step($urandom_range(0, 299) == 0);
        end
        c_we = 0; c_re = 0;
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
